mult_div_unit: RTL

Parametrised, iterative multiply/divide unit with HI/LO result registers for the MIPS datapath. It replaces the single-cycle `*` and `/` ALU paths with a sequential shift-add multiplier and restoring divider. It supports signed and unsigned modes and a start/busy/done handshake. It sits beside the main ALU, is driven by control on MULT/MULTU/DIV/DIVU/MTHI/MTLO, and HI/LO feed the register write-back mux for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// A shift-add multiplier and a restoring divider share one 2*WIDTH
// accumulator and retire one bit per cycle. Signed modes work on operand
// magnitudes; the recorded signs are applied in a single FIX cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO accepted
// CALC  | one multiply or divide iteration per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO write, done pulse raised
// DONE  | result just written; start here begins the next operation
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 is_div_q;
  logic                 zero_q;
  logic                 neg_q_q;
  logic                 neg_r_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;

  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 b_zero;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Operand conditioning at latch time: magnitudes for signed modes.
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    b_zero    = (b == '0);
  end

  // One iteration of each algorithm; the accumulator holds {upper, lower}.
  // Multiply: upper is the partial product, lower the remaining multiplier bits.
  // Divide: upper is the partial remainder, lower shifts dividend out / quotient in.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mcand_q};
    if (div_trial[WIDTH]) begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign application for the FIX cycle.
  always_comb begin
    prod_fix = neg_q_q ? -acc_q : acc_q;
    quo_fix  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Control FSM, datapath and HI/LO registers with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // MT writes only land while idle; a start in the same cycle still
      // launches and its result overwrites HI/LO later.
      if (!busy_q) begin
        if (mt_hi) hi_q <= wdata;
        if (mt_lo) lo_q <= wdata;
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            busy_q   <= 1'b1;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= op[1];
            zero_q   <= op[1] & b_zero;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            if (op[1] && b_zero) begin
              // Division by zero bypasses CALC; the raw dividend and an
              // all-ones quotient are parked in the accumulator for FIX.
              mcand_q <= '0;
              acc_q   <= {a, {WIDTH{1'b1}}};
              state_q <= FIX;
            end else if (op[1]) begin
              mcand_q <= b_mag;
              acc_q   <= {{WIDTH{1'b0}}, a_mag};
              state_q <= CALC;
            end else begin
              mcand_q <= a_mag;
              acc_q   <= {{WIDTH{1'b0}}, b_mag};
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end

        CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          if (cnt_q == LAST) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        FIX: begin
          if (zero_q) begin
            hi_q  <= acc_q[2*WIDTH-1:WIDTH];
            lo_q  <= acc_q[WIDTH-1:0];
            dbz_q <= 1'b1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
